// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: operation encodings carried on alu_control.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_BEQ  = 4'b1010,
        ALU_BNE  = 4'b1011,
        ALU_BLT  = 4'b1100,
        ALU_BGE  = 4'b1101,
        ALU_BLTU = 4'b1110,
        ALU_BGEU = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and zero/branch flag from op and operands.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]      alu_control_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    logic [XLEN-1:0] diff;
    logic [4:0]      shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    alu_op_e         op;

    assign op    = alu_op_e'(alu_control_i);
    assign diff  = a_i - b_i;
    assign shamt = b_i[4:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;
    assign eq    = a_i == b_i;

    always_comb begin
        result_o = '0;
        zero_o   = 1'b0;
        unique case (op)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = diff;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
            default:  result_o = diff;
        endcase

        // Branch codes report the condition on zero; all others flag a zero result.
        unique case (op)
            ALU_BEQ:  zero_o = eq;
            ALU_BNE:  zero_o = !eq;
            ALU_BLT:  zero_o = lt_s;
            ALU_BGE:  zero_o = !lt_s;
            ALU_BLTU: zero_o = lt_u;
            ALU_BGEU: zero_o = !lt_u;
            default:  zero_o = (result_o == '0);
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: alu_core followed by one stage of output registers.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        alu_control,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   alu_out,
    output logic              zero
);

    logic [XLEN-1:0] alu_out_d, alu_out_q;
    logic            zero_d, zero_q;

    alu_core u_core (
        .alu_control_i (alu_control),
        .a_i           (rs1_data),
        .b_i           (rs2_data),
        .result_o      (alu_out_d),
        .zero_o        (zero_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
        end
    end

    assign alu_out = alu_out_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour, random ops vs. a reference model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_control;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_out;
    logic        zero;

    int unsigned errors = 0;
    int unsigned checks = 0;

    alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_control (alu_control),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .alu_out     (alu_out),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model built from arithmetic on wide integers rather than bit operators.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z);
        longint ua, ub, sa, sb, p, q;
        int     ia, ib;
        int     sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = int'(a);
        ib = int'(b);
        sa = longint'(ia);
        sb = longint'(ib);
        sh = int'(ub % 32);
        p  = longint'(1) << sh;
        r  = 32'd0;
        z  = 1'b0;
        case (op)
            4'd0:  r = 32'(ua + ub);
            4'd1:  r = 32'(ua - ub);
            4'd2:  r = a ^ b;
            4'd3:  r = a | b;
            4'd4:  r = a & b;
            4'd5:  r = 32'(ua * p);
            4'd6:  r = 32'(ua / p);
            4'd7: begin
                if (sa >= 0) q = sa / p;
                else         q = -((-sa + p - 1) / p);
                r = 32'(q);
            end
            4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
            default: r = 32'(ua - ub);
        endcase
        case (op)
            4'd10: z = (ua == ub);
            4'd11: z = (ua != ub);
            4'd12: z = (sa < sb);
            4'd13: z = (sa >= sb);
            4'd14: z = (ua < ub);
            4'd15: z = (ua >= ub);
            default: z = (r == 32'd0);
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ez;
        model(op, a, b, er, ez);
        @(negedge clk);
        alu_control = op;
        rs1_data    = a;
        rs2_data    = b;
        @(posedge clk);
        #1;
        check({tag, ".out"}, alu_out, er);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    // Directed vector also checked against hand-derived constants.
    task automatic dir_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic exp_zero);
        run_op(tag, op, a, b);
        check({tag, ".out_const"}, alu_out, exp_out);
        check({tag, ".zero_const"}, {31'd0, zero}, {31'd0, exp_zero});
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [31:0] er;
        logic        ez;

        rst_n       = 1'b1;
        alu_control = 4'd0;
        rs1_data    = 32'd0;
        rs2_data    = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        check("reset.out", alu_out, 32'd0);
        check("reset.zero", {31'd0, zero}, 32'd0);
        rs1_data = 32'd1;
        @(posedge clk); #1;
        check("reset_hold.out", alu_out, 32'd0);
        check("reset_hold.zero", {31'd0, zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        dir_op("add",    4'd0,  32'd10, 32'd20, 32'd30, 1'b0);
        dir_op("sub",    4'd1,  32'd30, 32'd10, 32'd20, 1'b0);
        dir_op("xor",    4'd2,  32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF, 1'b0);
        dir_op("or",     4'd3,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0);
        dir_op("and",    4'd4,  32'hFFFF0000, 32'h00FFFF00, 32'h00FF0000, 1'b0);
        dir_op("sub0",   4'd1,  32'd7, 32'd7, 32'd0, 1'b1);
        dir_op("sll",    4'd5,  32'd1, 32'd4, 32'd16, 1'b0);
        dir_op("srl",    4'd6,  32'd16, 32'd2, 32'd4, 1'b0);
        dir_op("sra",    4'd7,  32'hFFFFFFF8, 32'd1, 32'hFFFFFFFC, 1'b0);
        dir_op("sll_hi", 4'd5,  32'd1, 32'h00000021, 32'd2, 1'b0);
        dir_op("sll0",   4'd5,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0);
        dir_op("slt",    4'd8,  32'hFFFFFFFB, 32'd3, 32'd1, 1'b0);
        dir_op("sltu",   4'd9,  32'd5, 32'd10, 32'd1, 1'b0);
        dir_op("sltu_b", 4'd9,  32'hFFFFFFFB, 32'd3, 32'd0, 1'b1);
        dir_op("beq",    4'd10, 32'd15, 32'd15, 32'd0, 1'b1);
        dir_op("bne",    4'd11, 32'd20, 32'd25, 32'hFFFFFFFB, 1'b1);
        dir_op("blt",    4'd12, 32'hFFFFFFFB, 32'd1, 32'hFFFFFFFA, 1'b1);
        dir_op("bge",    4'd13, 32'd10, 32'd5, 32'd5, 1'b1);
        dir_op("bltu",   4'd14, 32'd5, 32'd10, 32'hFFFFFFFB, 1'b1);
        dir_op("bgeu",   4'd15, 32'd100, 32'd50, 32'd50, 1'b1);
        dir_op("bgeu_f", 4'd15, 32'd5, 32'hFFFFFFFF, 32'd6, 1'b0);

        // Mid-stream reset: outputs nonzero, drop rst_n between edges.
        run_op("pre_rst", 4'd3, 32'hDEAD0000, 32'h0000BEEF);
        @(negedge clk);
        alu_control = 4'd0;
        rs1_data    = 32'd100;
        rs2_data    = 32'd23;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.out", alu_out, 32'd0);
        check("midrst.zero", {31'd0, zero}, 32'd0);
        @(posedge clk); #1;
        check("midrst_hold.out", alu_out, 32'd0);
        check("midrst_hold.zero", {31'd0, zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst.out", alu_out, 32'd123);
        check("post_rst.zero", {31'd0, zero}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = 32'($urandom_range(0, 40));
                2: a = 32'($urandom_range(0, 3));
                default: ;
            endcase
            model(op, a, b, er, ez);
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
